puf_resp_uart_tx: RTL
=====================

Name: puf_resp_uart_tx

Overview:
- Reads the 128-bit PUF response produced by the PUF collector (`puf_out` / `puf_done`) and sends it off-chip over a UART TX line.
- Captures the response on the rising edge of `puf_done`, then shifts out 16 bytes, MSB byte first, as 8N1 frames.
- Pulses `tx_done` once the last stop bit ends.
- Sits between the PUF collector and the board UART pin; consumer end of the response interface.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- NUM_BYTES, 16, bytes per response (128/8); fixed by the response width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- puf_out  in  128  PUF response from the collector.
- puf_done  in  1  level, high while the response is valid; stays high until the collector is reset.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from capture through the end of the last stop bit.
- tx_done  out  1  one-cycle pulse after the final stop bit.
- byte_idx  out  5  index of the byte currently on the line, 0..15; 0 when idle.

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: tx=1, busy=0, tx_done=0, byte_idx=0, state=IDLE, edge register done_q=0, counters=0.
- Trigger is a rising edge: `puf_done & ~done_q`, with done_q registered every cycle.
- Capture: on the trigger edge, load a 128-bit shadow register from `puf_out`, set busy=1, enter START.
  - tx drops to 0 in the following cycle.
  - Later changes to `puf_out` do not affect the frame in flight.
- Because done_q resets to 0, a `puf_done` held high through reset release triggers a fresh transmission.
- Triggers while busy=1 are ignored; done_q still tracks `puf_done`.
- A `puf_done` that stays high after completion never retriggers. A new send needs `puf_done` low then high again.
- Byte order: byte k = shadow[127-8k -: 8]. Byte 0 = bits [127:120].
- Frame per byte: start bit 0, then data bits d0..d7 (LSB first), then stop bit 1. Each bit holds exactly CLKS_PER_BIT cycles.
- Bytes go back-to-back with no idle gap. Total line time = 160*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx=1, waits for the trigger.
  - START: tx=0 for one bit time, then DATA.
  - DATA: bit_idx 0..7 via shift register; after bit 7, go to STOP.
  - STOP: tx=1 for one bit time. If byte_idx<15, increment byte_idx and go to START. Otherwise go to DONE.
  - DONE: one cycle; tx_done=1, busy=0, byte_idx=0; then IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- `rst` mid-operation: all outputs return to reset values at the next edge. tx=1 immediately, so the line may show a truncated frame. No tx_done is issued.

Decomposition:
- Shared package `puf_uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, DONE);
  - the default CLKS_PER_BIT;
  - FRAME_BITS=10;
  - RESP_BYTES=16.
- One sub-module, `uart_tx_byte`:
  - inputs `clk`, `rst`, `start`, `data[7:0]`; outputs `tx`, `ready`;
  - owns the baud counter, bit counter and shift register.
- `puf_resp_uart_tx` owns edge detection, the shadow register, byte sequencing, `busy` and `tx_done`.

Test Plan (CLKS_PER_BIT=4):
- Reset: rst held 3 cycles with `puf_done`=0 -> tx=1, busy=0, tx_done=0, byte_idx=0; line stays idle for 100 cycles.
- Normal send: puf_out=128'h000102030405060708090A0B0C0D0E0F, `puf_done` rises -> 16 frames decoding to bytes 0x00..0x0F in order. Every start bit is 0 and every stop bit is 1. Exactly 640 busy cycles, then a single tx_done pulse.
- Collector default value: puf_out=128'h5468697349734E6F74576F726B696E67 -> decoded ASCII "ThisIsNotWorking".
- Held `puf_done` plus input change: keep `puf_done`=1 after completion and alter `puf_out` during the send -> no second transmission; bytes sent match the captured value.
- Reset mid-send: assert rst during byte 5 DATA -> tx=1 and busy=0 next cycle, no tx_done. With `puf_done` still 1 at release, a full resend starts from byte 0.
- Retrigger: `puf_done` 1 -> 0 -> 1 after completion with a new `puf_out` -> second full transmission of the new value, one tx_done per transmission.

Source files
------------

// File: rtl/puf_resp_uart_tx_pkg.sv
// Shared types and constants for the PUF response UART transmitter.
package puf_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam int unsigned FRAME_BITS       = 10;
    localparam int unsigned RESP_BYTES       = 16;
    localparam int unsigned RESP_W           = RESP_BYTES * 8;
    localparam int unsigned IDX_W            = 5;

    // Bit-level UART framing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    // Response-level sequencing states.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_DONE
    } seq_t;

    // Byte k of the response, byte 0 being the most significant.
    function automatic logic [7:0] get_byte(input logic [RESP_W-1:0] resp, input logic [3:0] k);
        logic [RESP_W-1:0] sh;
        sh = resp >> (8 * (RESP_BYTES - 1 - 32'(k)));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/puf_resp_uart_tx_if.sv
// Response interface between the PUF collector (master) and its consumer (slave).
interface puf_resp_if;
    import puf_uart_pkg::*;

    logic [RESP_W-1:0] puf_out;
    logic              puf_done;
    logic              busy;
    logic              tx_done;
    logic [IDX_W-1:0]  byte_idx;

    modport master (output puf_out, output puf_done,
                    input  busy, input tx_done, input byte_idx);
    modport slave  (input  puf_out, input puf_done,
                    output busy, output tx_done, output byte_idx);
endinterface

// File: rtl/puf_resp_uart_tx_byte.sv
// Single-byte 8N1 UART transmitter; accepts a new byte in the last stop-bit cycle
// so consecutive frames run without an idle gap.
module uart_tx_byte
    import puf_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned DATA_BITS = FRAME_BITS - 2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             baud_last_c;

    assign baud_last_c = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign tx          = tx_q;
    assign ready       = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last_c) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (start) begin
                        state_d = START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Ready is a look-ahead: high in idle and during the final stop-bit cycle.
    always_comb begin
        ready_d = (state_d == IDLE) ||
                  ((state_d == STOP) && (baud_d == CNT_W'(CLKS_PER_BIT - 1)));
    end

endmodule

// File: rtl/puf_resp_uart_tx.sv
// Captures the 128-bit PUF response on the rising edge of puf_done and streams
// it MSB byte first over a UART line.
module puf_resp_uart_tx
    import puf_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    puf_resp_if.slave  resp,
    output logic       tx
);

    seq_t              state_q, state_d;
    logic              done_q;
    logic [RESP_W-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d, byte_nxt_c;
    logic              busy_q, busy_d;
    logic              tx_done_q, tx_done_d;
    logic              trig_c;
    logic              start_c;
    logic [7:0]        data_c;
    logic              ready;

    assign trig_c     = resp.puf_done & ~done_q;
    assign byte_nxt_c = byte_idx_q + IDX_W'(1);

    assign resp.busy     = busy_q;
    assign resp.tx_done  = tx_done_q;
    assign resp.byte_idx = byte_idx_q;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (start_c),
        .data  (data_c),
        .tx    (tx),
        .ready (ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            done_q     <= 1'b0;
            shadow_q   <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= resp.puf_done;
            shadow_q   <= shadow_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;
        start_c    = 1'b0;
        data_c     = get_byte(shadow_q, 4'(byte_nxt_c));
        unique case (state_q)
            SEQ_IDLE: begin
                // Byte 0 comes straight from the input so its start bit begins with capture.
                if (trig_c) begin
                    state_d    = SEQ_SEND;
                    shadow_d   = resp.puf_out;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                    start_c    = 1'b1;
                    data_c     = get_byte(resp.puf_out, 4'd0);
                end
            end
            SEQ_SEND: begin
                if (ready) begin
                    if (byte_idx_q != IDX_W'(RESP_BYTES - 1)) begin
                        start_c    = 1'b1;
                        byte_idx_d = byte_nxt_c;
                    end else begin
                        state_d    = SEQ_DONE;
                        byte_idx_d = '0;
                        busy_d     = 1'b0;
                        tx_done_d  = 1'b1;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

endmodule
